// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: op codes, FSM states and
// the width of the post-redirect flush counter.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_JUMP    = 3'd1,
    OP_BRZ     = 3'd2,
    OP_BRNZ    = 3'd3,
    OP_CALL    = 3'd4,
    OP_RET     = 3'd5,
    OP_HALT    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } seq_state_e;

  // FLUSH_CYCLES spans 1..3, so two bits are enough.
  localparam int FLUSH_CNT_W = 2;

  localparam int PC_W    = 8;
  localparam int DEPTH_W = 5;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: small LIFO of return addresses. Push wins over pop when both are
// asserted; overflow/underflow requests are ignored (the caller faults instead).
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [DW-1:0] top_idx;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign top_idx = depth_q - DW'(1);
  assign top     = mem_q[top_idx[IW-1:0]];

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[depth_q[IW-1:0]] = push_data;
      depth_d                = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Entry contents need no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: decodes control-flow ops into program-counter enable/overwrite
// controls, with flush bubbles after redirects. Optional return stack: PC_SEQ_RET_STACK_EN.
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter int STACK_DEPTH  = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         clk_en,
  input  logic [7:0]   pc_current,
  input  logic         op_valid,
  input  logic [2:0]   op_kind,
  input  logic [7:0]   op_target,
  input  logic         flag_zero,
  input  logic         stall,
  input  logic         resume,
  output logic         pc_clk_en,
  output logic         pc_overwrite_en,
  output logic [7:0]   pc_overwrite_data,
  output logic         flush,
  output logic         halted,
  output logic         fault,
  output logic [4:0]   stack_depth
);

  seq_state_e             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  op_kind_e               op;
  logic                   taken;
  logic [PC_W-1:0]        target;
  logic                   do_push, do_pop;
  logic [PC_W-1:0]        stack_top;
  logic                   stack_full, stack_empty;

`ifdef PC_SEQ_RET_STACK_EN
  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W),
    .DW    (DEPTH_W)
  ) u_ret_stack (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_current + 8'd1),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .depth     (stack_depth)
  );
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic unused_pc;
  logic unused_push_pop;
  assign unused_pc       = ^pc_current;
  assign unused_push_pop = do_push ^ do_pop ^ stack_full ^ stack_empty ^ (^stack_top);
  assign stack_top       = '0;
  assign stack_full      = 1'b0;
  assign stack_empty     = 1'b1;
  assign stack_depth     = '0;
`endif

  assign op = op_kind_e'(op_kind);

  always_comb begin
    state_d           = state_q;
    flush_cnt_d       = flush_cnt_q;
    pc_clk_en         = 1'b0;
    pc_overwrite_en   = 1'b0;
    pc_overwrite_data = '0;
    do_push           = 1'b0;
    do_pop            = 1'b0;
    taken             = 1'b0;
    target            = '0;
    // Reset and a frozen clock both leave every control low and state held.
    if (!sync_rst && clk_en) begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            if (!op_valid) begin
              pc_clk_en = 1'b1;
            end else begin
              case (op)
                OP_NONE: pc_clk_en = 1'b1;
                OP_JUMP: begin taken = 1'b1; target = op_target; end
                OP_BRZ: begin
                  if (flag_zero) begin taken = 1'b1; target = op_target; end
                  else pc_clk_en = 1'b1;
                end
                OP_BRNZ: begin
                  if (!flag_zero) begin taken = 1'b1; target = op_target; end
                  else pc_clk_en = 1'b1;
                end
`ifdef PC_SEQ_RET_STACK_EN
                OP_CALL: begin
                  if (stack_full) state_d = ST_FAULT;
                  else begin do_push = 1'b1; taken = 1'b1; target = op_target; end
                end
                OP_RET: begin
                  if (stack_empty) state_d = ST_FAULT;
                  else begin do_pop = 1'b1; taken = 1'b1; target = stack_top; end
                end
`else
                OP_CALL: begin taken = 1'b1; target = op_target; end
                OP_RET:  state_d = ST_FAULT;
`endif
                OP_HALT: state_d = ST_HALTED;
                default: state_d = ST_FAULT;
              endcase
            end
            if (taken) begin
              pc_clk_en         = 1'b1;
              pc_overwrite_en   = 1'b1;
              pc_overwrite_data = target;
              state_d           = ST_FLUSH;
              flush_cnt_d       = FLUSH_CNT_W'(FLUSH_CYCLES);
            end
          end
        end
        ST_FLUSH: begin
          if (!stall) begin
            pc_clk_en = 1'b1;
            if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
              flush_cnt_d = '0;
              state_d     = ST_RUN;
            end else begin
              flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            end
          end
        end
        ST_HALTED: begin
          if (resume) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush  = (state_q == ST_FLUSH);
  assign halted = (state_q == ST_HALTED);
  assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default parameters); return-stack
// expectations switch on PC_SEQ_RET_STACK_EN.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       sync_rst;
  logic       clk_en;
  logic [7:0] pc_current;
  logic       op_valid;
  logic [2:0] op_kind;
  logic [7:0] op_target;
  logic       flag_zero;
  logic       stall;
  logic       resume;
  logic       pc_clk_en;
  logic       pc_overwrite_en;
  logic [7:0] pc_overwrite_data;
  logic       flush;
  logic       halted;
  logic       fault;
  logic [4:0] stack_depth;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk               (clk),
    .sync_rst          (sync_rst),
    .clk_en            (clk_en),
    .pc_current        (pc_current),
    .op_valid          (op_valid),
    .op_kind           (op_kind),
    .op_target         (op_target),
    .flag_zero         (flag_zero),
    .stall             (stall),
    .resume            (resume),
    .pc_clk_en         (pc_clk_en),
    .pc_overwrite_en   (pc_overwrite_en),
    .pc_overwrite_data (pc_overwrite_data),
    .flush             (flush),
    .halted            (halted),
    .fault             (fault),
    .stack_depth       (stack_depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected pc-side controls for the inputs currently applied.
  task automatic chk_pc(input string tag, input logic en, input logic ow, input logic [7:0] data);
    #1;
    chk({tag, ".pc_clk_en"}, {7'd0, pc_clk_en}, {7'd0, en});
    chk({tag, ".ow_en"}, {7'd0, pc_overwrite_en}, {7'd0, ow});
    if (ow) chk({tag, ".ow_data"}, pc_overwrite_data, data);
  endtask

  task automatic chk_st(input string tag, input logic fl, input logic ha, input logic fa, input logic [4:0] dep);
    chk({tag, ".flush"}, {7'd0, flush}, {7'd0, fl});
    chk({tag, ".halted"}, {7'd0, halted}, {7'd0, ha});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, fa});
    chk({tag, ".depth"}, {3'd0, stack_depth}, {3'd0, dep});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [2:0] k, input logic [7:0] t);
    op_valid  = v;
    op_kind   = k;
    op_target = t;
  endtask

  task automatic do_reset();
    sync_rst = 1'b1;
    set_op(1'b1, 3'd1, 8'h55);
    chk_pc("rst_outs", 1'b0, 1'b0, 8'h00);
    chk("rst_data", pc_overwrite_data, 8'h00);
    tick();
    sync_rst = 1'b0;
    set_op(1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    sync_rst = 1'b1; clk_en = 1'b1; pc_current = 8'h00; flag_zero = 1'b0;
    stall = 1'b0; resume = 1'b0;
    set_op(1'b0, 3'd0, 8'h00);
    @(negedge clk);

    do_reset();
    chk_st("after_rst", 1'b0, 1'b0, 1'b0, 5'd0);

    // NONE for three cycles: plain increments
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 3'd0, 8'h00);
      chk_pc("none", 1'b1, 1'b0, 8'h00);
      tick();
      chk_st("none_st", 1'b0, 1'b0, 1'b0, 5'd0);
    end

    // JUMP 0x40: redirect now, one flush cycle after
    set_op(1'b1, 3'd1, 8'h40);
    chk_pc("jump", 1'b1, 1'b1, 8'h40);
    tick();
    chk_st("jump_fl", 1'b1, 1'b0, 1'b0, 5'd0);
    set_op(1'b1, 3'd1, 8'h99);
    chk_pc("flush_ignores_op", 1'b1, 1'b0, 8'h00);
    tick();
    chk_st("jump_done", 1'b0, 1'b0, 1'b0, 5'd0);

    // clk_en low freezes everything
    clk_en = 1'b0;
    set_op(1'b1, 3'd1, 8'h22);
    chk_pc("frozen", 1'b0, 1'b0, 8'h00);
    tick();
    chk_st("frozen_st", 1'b0, 1'b0, 1'b0, 5'd0);
    clk_en = 1'b1;

    // BRZ stalled two cycles, then not taken
    set_op(1'b1, 3'd2, 8'h10);
    flag_zero = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk_pc("brz_stall", 1'b0, 1'b0, 8'h00);
      tick();
      chk_st("brz_stall_st", 1'b0, 1'b0, 1'b0, 5'd0);
    end
    stall = 1'b0;
    flag_zero = 1'b0;
    chk_pc("brz_nt", 1'b1, 1'b0, 8'h00);
    tick();
    chk_st("brz_nt_st", 1'b0, 1'b0, 1'b0, 5'd0);

    // BRNZ taken, then a stall inside FLUSH extends it
    set_op(1'b1, 3'd3, 8'h2C);
    chk_pc("brnz", 1'b1, 1'b1, 8'h2C);
    tick();
    set_op(1'b0, 3'd0, 8'h00);
    stall = 1'b1;
    chk_pc("flush_stall", 1'b0, 1'b0, 8'h00);
    tick();
    chk_st("flush_held", 1'b1, 1'b0, 1'b0, 5'd0);
    stall = 1'b0;
    chk_pc("flush_go", 1'b1, 1'b0, 8'h00);
    tick();
    chk_st("flush_exit", 1'b0, 1'b0, 1'b0, 5'd0);

    // CALL 0x80 at pc 0xFF, then RET
    pc_current = 8'hFF;
    set_op(1'b1, 3'd4, 8'h80);
    chk_pc("call", 1'b1, 1'b1, 8'h80);
    tick();
    set_op(1'b0, 3'd0, 8'h00);
`ifdef PC_SEQ_RET_STACK_EN
    chk_st("call_st", 1'b1, 1'b0, 1'b0, 5'd1);
    tick();
    pc_current = 8'h81;
    set_op(1'b1, 3'd5, 8'h00);
    chk_pc("ret", 1'b1, 1'b1, 8'h00);
    tick();
    chk_st("ret_st", 1'b1, 1'b0, 1'b0, 5'd0);
    set_op(1'b0, 3'd0, 8'h00);
    tick();
`else
    chk_st("call_st", 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
`endif

    // HALT, three idle cycles with ops offered, then resume
    set_op(1'b1, 3'd6, 8'h00);
    chk_pc("halt", 1'b0, 1'b0, 8'h00);
    tick();
    set_op(1'b1, 3'd1, 8'h33);
    for (int i = 0; i < 3; i++) begin
      chk_pc("halted", 1'b0, 1'b0, 8'h00);
      tick();
      chk_st("halted_st", 1'b0, 1'b1, 1'b0, 5'd0);
    end
    set_op(1'b0, 3'd0, 8'h00);
    resume = 1'b1;
    chk_pc("resume", 1'b0, 1'b0, 8'h00);
    tick();
    resume = 1'b0;
    chk_st("resumed", 1'b0, 1'b0, 1'b0, 5'd0);
    chk_pc("run_again", 1'b1, 1'b0, 8'h00);

`ifdef PC_SEQ_RET_STACK_EN
    // Five CALLs into a 4-deep stack
    for (int i = 0; i < 4; i++) begin
      pc_current = 8'(8'h10 * i);
      set_op(1'b1, 3'd4, 8'(8'hA0 + i));
      chk_pc("call_n", 1'b1, 1'b1, 8'(8'hA0 + i));
      tick();
      set_op(1'b0, 3'd0, 8'h00);
      tick();
    end
    chk_st("stack_full", 1'b0, 1'b0, 1'b0, 5'd4);
    set_op(1'b1, 3'd4, 8'hB0);
    chk_pc("call_ovf", 1'b0, 1'b0, 8'h00);
    tick();
    chk_st("ovf_fault", 1'b0, 1'b0, 1'b1, 5'd4);
`else
    // RET without a stack is illegal
    set_op(1'b1, 3'd5, 8'h00);
    chk_pc("ret_illegal", 1'b0, 1'b0, 8'h00);
    tick();
    chk_st("ret_fault", 1'b0, 1'b0, 1'b1, 5'd0);
`endif
    // FAULT is sticky through resume and new ops
    resume = 1'b1;
    set_op(1'b1, 3'd1, 8'h44);
    chk_pc("fault_hold", 1'b0, 1'b0, 8'h00);
    tick();
    chk("fault_sticky", {7'd0, fault}, 8'h01);
    resume = 1'b0;
    do_reset();
    chk_st("fault_cleared", 1'b0, 1'b0, 1'b0, 5'd0);

    // Illegal op 7
    set_op(1'b1, 3'd7, 8'h12);
    chk_pc("op7", 1'b0, 1'b0, 8'h00);
    tick();
    chk_st("op7_fault", 1'b0, 1'b0, 1'b1, 5'd0);
    do_reset();

    // Reset in mid-FLUSH returns to RUN
    set_op(1'b1, 3'd1, 8'h70);
    chk_pc("jump2", 1'b1, 1'b1, 8'h70);
    tick();
    chk("mid_flush", {7'd0, flush}, 8'h01);
    do_reset();
    chk_st("flush_rst", 1'b0, 1'b0, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control sequencer for the 8-bit program counter. It decodes per-cycle control-flow ops (jump, conditional branch, call, return, halt) and drives the counter's enable, overwrite-enable and overwrite-data inputs. It also holds a small return-address stack and issues fetch-flush bubbles after every taken redirect. It sits between instruction decode and the program counter.

## Interface
- STACK_DEPTH, 4: return-stack entries; legal range 2–16.
- FLUSH_CYCLES, 1: flush cycles after a taken redirect; legal range 1–3.
- clk  in  1  system clock
- sync_rst  in  1  synchronous, active-high reset
- clk_en  in  1  global advance enable; low freezes all state
- pc_current  in  8  program counter output
- op_valid  in  1  op_kind/op_target valid this cycle
- op_kind  in  3  op code: NONE=0, JUMP=1, BRZ=2, BRNZ=3, CALL=4, RET=5, HALT=6; 7 is illegal
- op_target  in  8  absolute redirect address
- flag_zero  in  1  zero flag for BRZ/BRNZ
- stall  in  1  downstream stall; holds the PC
- resume  in  1  leave HALTED
- pc_clk_en  out  1  to program counter clk_en
- pc_overwrite_en  out  1  to program counter overwrite_en
- pc_overwrite_data  out  8  to program counter overwrite_data
- flush  out  1  squash the fetched instruction
- halted  out  1  in HALTED state
- fault  out  1  in FAULT state
- stack_depth  out  5  current return-stack occupancy

## Operation
- States: RUN, FLUSH, HALTED, FAULT. State and stack are registered. pc_* outputs are combinational from state and the inputs. flush, halted and fault decode from state.
- When clk_en=0: all state frozen; pc_clk_en=0, pc_overwrite_en=0.
- RUN with stall=1: pc_clk_en=0; the op is not consumed, and decode must hold it.
- RUN, stall=0, and op_valid=0 or op NONE: pc_clk_en=1 (increment).
- RUN, taken op: pc_clk_en=1, pc_overwrite_en=1, then go to FLUSH with the counter loaded with FLUSH_CYCLES.
  - JUMP: data = op_target.
  - BRZ: taken if flag_zero=1. BRNZ: taken if flag_zero=0. A not-taken branch increments and stays in RUN.
  - CALL: push (pc_current+1) mod 256, so 0xFF pushes 0x00; data = op_target.
  - RET: pop; data = the popped entry.
- RUN, HALT op: pc_clk_en=0; go to HALTED.
- RUN, op_kind 7: go to FAULT; no redirect.
- CALL with the stack full, or RET with it empty: go to FAULT. pc_clk_en=0, no push/pop, no redirect.
- FLUSH: pc_clk_en=1 (increment), flush=1, op_valid ignored. Stall is also honoured here (pc_clk_en=0, counter holds). Return to RUN when the counter reaches 0.
- HALTED: pc_clk_en=0. resume=1 with clk_en=1 returns to RUN next cycle. resume is ignored in every other state.
- FAULT: pc_clk_en=0. Sticky; only sync_rst exits.

## Timing
- sync_rst is sampled at the rising edge and overrides clk_en and every other input.
- Reset result: state RUN, stack empty, stack_depth=0, flush=0, halted=0, fault=0.
- While sync_rst=1: pc_clk_en=0, pc_overwrite_en=0, pc_overwrite_data=0. The counter resets itself.
- Redirect latency is zero: the counter loads the target on the same edge the op is presented.
- FLUSH covers exactly FLUSH_CYCLES enabled, unstalled cycles after that edge.
- Push and pop take effect at the redirect edge. stack_depth updates one cycle later and is registered.
- Simultaneous stall and op: stall wins. Reset in mid-FLUSH or HALTED: the next state is RUN with the stack cleared.

## Configuration
- PC_SEQ_RET_STACK_EN defined: CALL/RET behave as above, with a return stack of STACK_DEPTH entries.
- PC_SEQ_RET_STACK_EN undefined:
  - No stack storage.
  - CALL behaves exactly as JUMP.
  - RET behaves as an illegal op and goes to FAULT.
  - stack_depth is tied to 0.

## Structure
- Package pc_seq_pkg holds:
  - the op_kind enum (3-bit)
  - the state enum (2-bit)
  - the FLUSH_CYCLES counter width constant
- Sub-module ret_stack: a parameterised LIFO.
  - Inputs: push, pop, push_data.
  - Outputs: top, full, empty, depth.
  - It has its own clk/sync_rst and is instantiated only under PC_SEQ_RET_STACK_EN.

## Test plan
- Reset, then NONE for 3 cycles → pc_clk_en=1 each cycle, overwrite_en=0; flush, halted and fault all 0.
- JUMP 0x40 with FLUSH_CYCLES=1 → overwrite_en=1, data=0x40 that cycle; flush=1 for the next cycle only.
- CALL 0x80 at pc_current=0xFF, then RET → push 0x00; RET redirects to 0x00; stack_depth goes 1 then 0.
- Five CALLs with STACK_DEPTH=4 → the fifth gives fault=1 and pc_clk_en=0; state held until sync_rst, then fault=0.
- BRZ 0x10 with stall=1 for 2 cycles, then stall=0 and flag_zero=0 → no advance while stalled, then a plain increment.
- HALT, wait 3 cycles, then resume → halted=1 and pc_clk_en=0 throughout; RUN on the cycle after resume.
